pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
Pipeline stall/flush sequencer for the 5-stage core; it consumes hazard conditions and drives the pipeline-register enables and bubble/flush controls.
- Resolves load-use interlocks that forwarding cannot cover: load in EX feeding a consumer in ID.
- Freezes the pipe during multi-cycle data-memory accesses, inserts front-end bubbles on instruction-memory misses, squashes wrong-path instructions on EX-resolved redirects, and latches HALT.
- Sits between the forwarding logic and the stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
REG_AW, 3, register-specifier width (8 GPRs)
CNT_W, 16, width of the optional performance counters

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
dec_ReadReg1  in  REG_AW  ID source register 1
dec_ReadReg2  in  REG_AW  ID source register 2
dec_Uses1  in  1  ID instruction actually reads ReadReg1
dec_Uses2  in  1  ID instruction actually reads ReadReg2
dec_Halt  in  1  ID holds HALT
exe_WriteReg  in  REG_AW  EX destination register
exe_RegWrite  in  1  EX writes a register
exe_DMemRead  in  1  EX instruction is a load
exe_Redirect  in  1  EX resolved a taken branch/jump (wrong-path in IF, ID)
imem_Busy  in  1  instruction memory not ready this cycle
dmem_Busy  in  1  data memory (MEM stage) not ready this cycle
pc_En  out  1  PC update enable
ifid_En  out  1  IF/ID load enable
ifid_Flush  out  1  IF/ID loads a NOP
idex_En  out  1  ID/EX load enable
idex_Bubble  out  1  ID/EX loads a NOP
exmem_En  out  1  EX/MEM load enable
memwb_En  out  1  MEM/WB load enable
redirect_Take  out  1  PC mux selects the redirect target this cycle
halted  out  1  core halted (sticky)

Behaviour:
- States: RUN, MEM_WAIT, HALTED. Outputs are Mealy: a function of state, inputs and the redirect_pend register.
- Reset (async, while rst=1):
  - pc_En=ifid_En=idex_En=exmem_En=memwb_En=0.
  - ifid_Flush=idex_Bubble=1, redirect_Take=0, halted=0.
  - State RUN, redirect_pend=0.
  - First cycle after release is normal RUN.
- Load-use hazard: lu = exe_DMemRead & exe_RegWrite & ((dec_Uses1 & exe_WriteReg==dec_ReadReg1) | (dec_Uses2 & exe_WriteReg==dec_ReadReg2)).
- Priority in RUN, highest first:
  1. dmem_Busy: all En=0, no flush/bubble. Go to MEM_WAIT; if exe_Redirect, set redirect_pend.
  2. exe_Redirect: redirect_Take=1, pc_En=1, ifid_Flush=1, idex_Bubble=1; EX/MEM and MEM/WB advance. lu is ignored because the ID instruction is wrong-path.
  3. lu: pc_En=0, ifid_En=0, idex_Bubble=1; EX/MEM and MEM/WB advance. Exactly one bubble per load-use pair; the next cycle's forwarding covers MEM to EX.
  4. imem_Busy: pc_En=0, ifid_Flush=1; ID onward advance.
  5. Otherwise all En=1, no flush/bubble.
- MEM_WAIT:
  - While dmem_Busy=1: all En=0; any exe_Redirect sets redirect_pend.
  - On dmem_Busy=0: return to RUN, and the same cycle is evaluated with RUN rules, with (exe_Redirect | redirect_pend) as the redirect term.
  - redirect_pend clears whenever redirect_Take=1.
- HALT:
  - Condition: dec_Halt in RUN with no freeze, redirect or lu.
  - That cycle: pc_En=0, ifid_En=0; HALT advances to ID/EX.
  - Next cycle: state HALTED, halted=1, pc_En=ifid_En=0, ifid_Flush=1.
  - Back end keeps draining and still honours dmem_Busy freezes.
  - Exit only via rst.
- Simultaneous lu and imem_Busy: lu wins; the PC is already held.
- rst mid-MEM_WAIT discards redirect_pend.

Optional Feature:
STALL_PERF_CNT_EN:
- When defined, adds CNT_W-bit outputs cnt_LoadUse, cnt_MemWait, cnt_Flush.
- Each increments by 1 per cycle in which case 3, case 1 or MEM_WAIT-freeze, or case 2 applies, respectively.
- Counters saturate at all-ones and clear on rst.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: state enum (RUN, MEM_WAIT, HALTED), REG_AW default, NOP encoding constant.
- Sub-module lu_detect: combinational load-use comparator, reused for a second read port later.

Test Plan:
- Reset then idle: all En=1, flush/bubble=0, halted=0 on the first cycle after release.
- Load r3 in EX, ID reads r3 with Uses1=1: one cycle pc_En=0, ifid_En=0, idex_Bubble=1, then normal.
- Same load, ID reads r3 with Uses1=0: no stall.
- dmem_Busy for 3 cycles with exe_Redirect in cycle 2: all En=0 for 3 cycles; on the 4th cycle redirect_Take=1, ifid_Flush=1, idex_Bubble=1.
- exe_Redirect with lu and imem_Busy all high: redirect_Take=1, pc_En=1, flush + bubble, no load-use stall.
- dec_Halt in ID: one cycle pc_En=0, then halted=1 sticky; dmem_Busy still freezes the back end; rst clears halted.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_pkg: shared definitions for the pipeline stall/flush sequencer.
//   stall_state_t : sequencer states (RUN, MEM_WAIT, HALTED)
//   ctrl_t        : bundle of stage-register controls driven by the sequencer
//   REG_AW_DEF    : default register-specifier width (8 GPRs)
//   NOP_INSTR     : instruction word the stage registers load on flush/bubble
package pipe_pkg;

  localparam int REG_AW_DEF = 3;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } stall_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_en;
    logic redirect_take;
  } ctrl_t;

  // All enables at the given level, no flush/bubble/redirect.
  function automatic ctrl_t ctrl_all(input logic en);
    ctrl_t c;
    c               = '0;
    c.pc_en         = en;
    c.ifid_en       = en;
    c.idex_en       = en;
    c.exmem_en      = en;
    c.memwb_en      = en;
    return c;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_lu_detect.sv
// lu_detect: combinational load-use comparator.
//   rd_a/rd_b   : consumer source specifiers, use_a/use_b : they are really read
//   wr_reg      : producer destination, reg_write/mem_read : producer is a load
//   hit         : consumer needs the load result before forwarding can supply it
module lu_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rd_a,
  input  logic [REG_AW-1:0] rd_b,
  input  logic              use_a,
  input  logic              use_b,
  input  logic [REG_AW-1:0] wr_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  output logic              hit
);

  logic match_a;
  logic match_b;

  assign match_a = use_a && (wr_reg == rd_a);
  assign match_b = use_b && (wr_reg == rd_b);
  assign hit     = mem_read && reg_write && (match_a || match_b);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush sequencer for the 5-stage core.
// Inputs : ID source specifiers/uses/HALT, EX destination/load/redirect,
//          instruction- and data-memory busy flags.
// Outputs: PC and stage-register enables, IF/ID flush, ID/EX bubble,
//          redirect_Take (PC mux select) and sticky halted.
// Optional: define STALL_PERF_CNT_EN to add saturating counters
//          cnt_LoadUse, cnt_MemWait, cnt_Flush (CNT_W bits each).
// Outputs are Mealy; while rst is high they are forced to the reset pattern
// (all enables low, flush and bubble high).
// Handshake: none -- every output is a per-cycle level qualified by the
// current inputs; the stage registers sample them on the next clk edge.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] dec_ReadReg1,
  input  logic [REG_AW-1:0] dec_ReadReg2,
  input  logic              dec_Uses1,
  input  logic              dec_Uses2,
  input  logic              dec_Halt,
  input  logic [REG_AW-1:0] exe_WriteReg,
  input  logic              exe_RegWrite,
  input  logic              exe_DMemRead,
  input  logic              exe_Redirect,
  input  logic              imem_Busy,
  input  logic              dmem_Busy,
  output logic              pc_En,
  output logic              ifid_En,
  output logic              ifid_Flush,
  output logic              idex_En,
  output logic              idex_Bubble,
  output logic              exmem_En,
  output logic              memwb_En,
  output logic              redirect_Take,
`ifdef STALL_PERF_CNT_EN
  output logic [CNT_W-1:0]  cnt_LoadUse,
  output logic [CNT_W-1:0]  cnt_MemWait,
  output logic [CNT_W-1:0]  cnt_Flush,
`endif
  output logic              halted
);

  stall_state_t state, state_nxt;
  logic         redirect_pend, pend_nxt;
  logic         lu;
  logic         redir;
  ctrl_t        ctrl;
  logic         halted_c;
  logic         ev_lu, ev_mem, ev_flush;

  lu_detect #(.REG_AW(REG_AW)) u_lu (
    .rd_a      (dec_ReadReg1),
    .rd_b      (dec_ReadReg2),
    .use_a     (dec_Uses1),
    .use_b     (dec_Uses2),
    .wr_reg    (exe_WriteReg),
    .reg_write (exe_RegWrite),
    .mem_read  (exe_DMemRead),
    .hit       (lu)
  );

  // A redirect seen during a data-memory freeze is replayed on release.
  assign redir = exe_Redirect | redirect_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      redirect_pend <= 1'b0;
    end else begin
      state         <= state_nxt;
      redirect_pend <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = redirect_pend;
    ctrl      = ctrl_all(1'b1);
    halted_c  = 1'b0;
    ev_lu     = 1'b0;
    ev_mem    = 1'b0;
    ev_flush  = 1'b0;
    case (state)
      RUN, MEM_WAIT: begin
        // MEM_WAIT with dmem ready is evaluated exactly like RUN.
        if (dmem_Busy) begin
          ctrl      = ctrl_all(1'b0);
          state_nxt = MEM_WAIT;
          pend_nxt  = redirect_pend | exe_Redirect;
          ev_mem    = 1'b1;
        end else if (redir) begin
          ctrl.redirect_take = 1'b1;
          ctrl.ifid_flush    = 1'b1;
          ctrl.idex_bubble   = 1'b1;
          state_nxt          = RUN;
          pend_nxt           = 1'b0;
          ev_flush           = 1'b1;
        end else if (lu) begin
          // Single bubble: next cycle the load is in MEM and forwards to EX.
          ctrl.pc_en       = 1'b0;
          ctrl.ifid_en     = 1'b0;
          ctrl.idex_bubble = 1'b1;
          state_nxt        = RUN;
          ev_lu            = 1'b1;
        end else if (dec_Halt) begin
          // HALT moves into ID/EX; the front end stops for good.
          ctrl.pc_en   = 1'b0;
          ctrl.ifid_en = 1'b0;
          state_nxt    = HALTED;
        end else if (imem_Busy) begin
          ctrl.pc_en      = 1'b0;
          ctrl.ifid_flush = 1'b1;
          state_nxt       = RUN;
        end else begin
          state_nxt = RUN;
        end
      end
      HALTED: begin
        halted_c        = 1'b1;
        ctrl.pc_en      = 1'b0;
        ctrl.ifid_en    = 1'b0;
        ctrl.ifid_flush = 1'b1;
        if (dmem_Busy) begin
          ctrl.idex_en  = 1'b0;
          ctrl.exmem_en = 1'b0;
          ctrl.memwb_en = 1'b0;
        end else begin
          // ID still holds HALT; feed NOPs behind it while the back end drains.
          ctrl.idex_bubble = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        pend_nxt  = 1'b0;
      end
    endcase
    if (rst) begin
      ctrl             = ctrl_all(1'b0);
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_bubble = 1'b1;
      halted_c         = 1'b0;
    end
  end

  assign pc_En         = ctrl.pc_en;
  assign ifid_En       = ctrl.ifid_en;
  assign ifid_Flush    = ctrl.ifid_flush;
  assign idex_En       = ctrl.idex_en;
  assign idex_Bubble   = ctrl.idex_bubble;
  assign exmem_En      = ctrl.exmem_en;
  assign memwb_En      = ctrl.memwb_en;
  assign redirect_Take = ctrl.redirect_take;
  assign halted        = halted_c;

`ifdef STALL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_LoadUse <= '0;
      cnt_MemWait <= '0;
      cnt_Flush   <= '0;
    end else begin
      if (ev_lu && cnt_LoadUse != CNT_MAX)    cnt_LoadUse <= cnt_LoadUse + CNT_ONE;
      if (ev_mem && cnt_MemWait != CNT_MAX)   cnt_MemWait <= cnt_MemWait + CNT_ONE;
      if (ev_flush && cnt_Flush != CNT_MAX)   cnt_Flush   <= cnt_Flush + CNT_ONE;
    end
  end
`else
  logic unused_ev;
  assign unused_ev = ev_lu ^ ev_mem ^ ev_flush;
`endif

endmodule
